// File: rtl/nw_pkg.sv
// ============================================================================
// Package : nw_pkg
// Shared constants, direction codes, FSM states and score saturation helper.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package nw_pkg;

  localparam int c_N  = 128;
  localparam int c_SW = 9;

  localparam logic signed [c_SW-1:0] c_MATCH    = 9'sd1;
  localparam logic signed [c_SW-1:0] c_MISMATCH = -9'sd1;
  localparam logic signed [c_SW-1:0] c_GAP      = -9'sd2;

  localparam logic [1:0] c_DIR_DIAG = 2'b00;
  localparam logic [1:0] c_DIR_UP   = 2'b01;
  localparam logic [1:0] c_DIR_LEFT = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_DIAG = 3'd1,
    ST_RD_UP   = 3'd2,
    ST_RD_LEFT = 3'd3,
    ST_CAPT    = 3'd4,
    ST_CALC    = 3'd5,
    ST_WRITE   = 3'd6,
    ST_NEXT    = 3'd7
  } state_t;

  // Overflow shows as the two top bits of the widened sum disagreeing.
  function automatic logic [c_SW-1:0] sat_score(input logic [c_SW:0] x);
    if (x[c_SW] != x[c_SW-1])
      return x[c_SW] ? {1'b1, {(c_SW-1){1'b0}}} : {1'b0, {(c_SW-1){1'b1}}};
    return x[c_SW-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/score_max3.sv
// ============================================================================
// Module : score_max3
// Forms the three saturated candidates and picks the best (diag > up > left).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module score_max3
  import nw_pkg::*;
#(
  parameter logic signed [c_SW-1:0] MATCH    = c_MATCH,
  parameter logic signed [c_SW-1:0] MISMATCH = c_MISMATCH,
  parameter logic signed [c_SW-1:0] GAP      = c_GAP
) (
  input  logic signed [c_SW-1:0] diag,
  input  logic signed [c_SW-1:0] up,
  input  logic signed [c_SW-1:0] left,
  input  logic                   is_match,
  output logic signed [c_SW-1:0] best,
  output logic [1:0]             best_dir
);

  logic signed [c_SW-1:0] w_sub;
  logic [c_SW:0]          w_d_sum;
  logic [c_SW:0]          w_u_sum;
  logic [c_SW:0]          w_l_sum;
  logic signed [c_SW-1:0] w_d;
  logic signed [c_SW-1:0] w_u;
  logic signed [c_SW-1:0] w_l;

  assign w_sub   = is_match ? MATCH : MISMATCH;
  assign w_d_sum = {diag[c_SW-1], diag} + {w_sub[c_SW-1], w_sub};
  assign w_u_sum = {up[c_SW-1], up} + {GAP[c_SW-1], GAP};
  assign w_l_sum = {left[c_SW-1], left} + {GAP[c_SW-1], GAP};

  assign w_d = $signed(sat_score(w_d_sum));
  assign w_u = $signed(sat_score(w_u_sum));
  assign w_l = $signed(sat_score(w_l_sum));

  always_comb begin
    best     = w_l;
    best_dir = c_DIR_LEFT;
    if (w_d >= w_u && w_d >= w_l) begin
      best     = w_d;
      best_dir = c_DIR_DIAG;
    end else if (w_u >= w_l) begin
      best     = w_u;
      best_dir = c_DIR_UP;
    end
  end

endmodule

`default_nettype wire

// File: rtl/score_cell_engine.sv
// ============================================================================
// Module : score_cell_engine
// Walks cells (0,0)..(N-1,N-1): three score RAM reads, score, one write pulse.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module score_cell_engine
  import nw_pkg::*;
#(
  parameter int                     N        = c_N,
  parameter logic signed [c_SW-1:0] MATCH    = c_MATCH,
  parameter logic signed [c_SW-1:0] MISMATCH = c_MISMATCH,
  parameter logic signed [c_SW-1:0] GAP      = c_GAP,
  parameter int                     AW       = $clog2((N + 1) * (N + 1))
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [1:0]             char_a,
  input  logic [1:0]             char_b,
  output logic                   rd_en,
  output logic [AW-1:0]          rd_addr,
  input  logic signed [c_SW-1:0] rd_data,
  output logic [$clog2(N):0]     i,
  output logic [$clog2(N):0]     j,
  output logic                   en_ins,
  output logic signed [c_SW-1:0] max,
  output logic [1:0]             dir,
  output logic                   busy,
  output logic                   done
);

  localparam int c_IW = $clog2(N) + 1;
  localparam logic [c_IW-1:0] c_LAST = c_IW'(N - 1);

  state_t                 r_state;
  logic [c_IW-1:0]        r_i;
  logic [c_IW-1:0]        r_j;
  logic signed [c_SW-1:0] r_diag;
  logic signed [c_SW-1:0] r_up;
  logic signed [c_SW-1:0] r_left;
  logic signed [c_SW-1:0] r_max;
  logic [1:0]             r_dir;
  logic                   r_rd_en;
  logic [AW-1:0]          r_rd_addr;
  logic                   r_en_ins;
  logic                   r_busy;
  logic                   r_done;

  logic signed [c_SW-1:0] w_best;
  logic [1:0]             w_best_dir;
  logic                   w_row_end;
  logic                   w_last;
  logic [c_IW-1:0]        w_i_nxt;
  logic [c_IW-1:0]        w_j_nxt;
  logic [AW-1:0]          w_base;
  logic [AW-1:0]          w_next_base;

  score_max3 #(
    .MATCH    (MATCH),
    .MISMATCH (MISMATCH),
    .GAP      (GAP)
  ) u_max3 (
    .diag     (r_diag),
    .up       (r_up),
    .left     (r_left),
    .is_match (char_a == char_b),
    .best     (w_best),
    .best_dir (w_best_dir)
  );

  assign w_row_end   = (r_j == c_LAST);
  assign w_last      = w_row_end && (r_i == c_LAST);
  assign w_j_nxt     = w_row_end ? '0 : r_j + c_IW'(1);
  assign w_i_nxt     = w_row_end ? r_i + c_IW'(1) : r_i;
  assign w_base      = AW'(r_i) * AW'(N + 1) + AW'(r_j);
  assign w_next_base = AW'(w_i_nxt) * AW'(N + 1) + AW'(w_j_nxt);

  // Outputs are registered, so each read strobe/address is loaded on entry
  // to its read state; the address is forced back to 0 everywhere else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_i       <= '0;
      r_j       <= '0;
      r_diag    <= '0;
      r_up      <= '0;
      r_left    <= '0;
      r_max     <= '0;
      r_dir     <= '0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_en_ins  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_en_ins  <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_RD_DIAG;
            r_i     <= '0;
            r_j     <= '0;
            r_rd_en <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ST_RD_DIAG: begin
          r_state   <= ST_RD_UP;
          r_rd_en   <= 1'b1;
          r_rd_addr <= w_base + AW'(1);
        end
        ST_RD_UP: begin
          r_diag    <= rd_data;
          r_state   <= ST_RD_LEFT;
          r_rd_en   <= 1'b1;
          r_rd_addr <= w_base + AW'(N + 1);
        end
        ST_RD_LEFT: begin
          r_up    <= rd_data;
          r_state <= ST_CAPT;
        end
        ST_CAPT: begin
          r_left  <= rd_data;
          r_state <= ST_CALC;
        end
        ST_CALC: begin
          r_max    <= w_best;
          r_dir    <= w_best_dir;
          r_en_ins <= 1'b1;
          r_state  <= ST_WRITE;
        end
        ST_WRITE: begin
          r_state <= ST_NEXT;
        end
        ST_NEXT: begin
          if (w_last) begin
            r_state <= ST_IDLE;
            r_i     <= '0;
            r_j     <= '0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_state   <= ST_RD_DIAG;
            r_i       <= w_i_nxt;
            r_j       <= w_j_nxt;
            r_rd_en   <= 1'b1;
            r_rd_addr <= w_next_base;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_en   = r_rd_en;
  assign rd_addr = r_rd_addr;
  assign i       = r_i;
  assign j       = r_j;
  assign en_ins  = r_en_ins;
  assign max     = r_max;
  assign dir     = r_dir;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_score_cell_engine.sv
// ============================================================================
// Module : tb_score_cell_engine
// Score RAM model plus directed cell vectors and randomized full-matrix runs.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_score_cell_engine;

  localparam int N   = 4;
  localparam int ROW = N + 1;
  localparam int AW  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [1:0]        char_a;
  logic [1:0]        char_b;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic signed [8:0] rd_data;
  logic [2:0]        i;
  logic [2:0]        j;
  logic              en_ins;
  logic signed [8:0] max;
  logic [1:0]        dir;
  logic              busy;
  logic              done;

  score_cell_engine #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .char_a(char_a), .char_b(char_b),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .i(i), .j(j),
    .en_ins(en_ins), .max(max), .dir(dir), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Score RAM: 1-cycle read latency, loader port, and the cell writer.
  logic signed [8:0] ram [0:ROW*ROW-1];
  logic              ld_en = 1'b0;
  int                ld_addr = 0;
  logic signed [8:0] ld_data = '0;
  always @(posedge clk) begin
    if (ld_en) ram[ld_addr] <= ld_data;
    else if (en_ins) ram[(int'(i) + 1) * ROW + int'(j) + 1] <= max;
    if (rd_en) rd_data <= ram[rd_addr];
  end

  logic [1:0] seq_a [0:7];
  logic [1:0] seq_b [0:7];
  assign char_a = seq_a[i];
  assign char_b = seq_b[j];

  // Monitor
  logic clr_req = 1'b0;
  int   en_i[$], en_j[$], en_max[$], en_dir[$], en_cyc[$], rd_q[$];
  int   done_n = 0, done_cyc = 0, addr_bad = 0;
  always @(negedge clk) begin
    if (clr_req) begin
      en_i.delete(); en_j.delete(); en_max.delete(); en_dir.delete();
      en_cyc.delete(); rd_q.delete();
      done_n <= 0; addr_bad <= 0;
    end else begin
      if (en_ins) begin
        en_i.push_back(int'(i)); en_j.push_back(int'(j));
        en_max.push_back(int'(max)); en_dir.push_back(int'(dir));
        en_cyc.push_back(cyc);
      end
      if (done) begin done_n <= done_n + 1; done_cyc <= cyc; end
      if (rd_en) rd_q.push_back(int'(rd_addr));
      else if (rd_addr != '0) addr_bad <= addr_bad + 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    clr_req = 1'b1;
    @(negedge clk);
    #1 clr_req = 1'b0;
  endtask

  task automatic load(input int addr, input int data);
    ld_en = 1'b1; ld_addr = addr; ld_data = 9'(data);
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic do_start(output int s_cyc);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    s_cyc = cyc;
  endtask

  task automatic check_all_zero(input string name);
    logic [25:0] w;
    w = {rd_en, rd_addr, i, j, en_ins, max, dir, busy, done};
    check(name, int'(w), 0);
  endtask

  function automatic int sat(input int v);
    if (v > 255) return 255;
    if (v < -256) return -256;
    return v;
  endfunction

  typedef struct {
    int diag; int up; int left;
    logic [1:0] ca; logic [1:0] cb;
    int emax; int edir;
  } vec_t;
  vec_t vt [8];

  int g [0:N][0:N];
  int gdir [0:N][0:N];

  initial begin
    int s_cyc, lat, d, u, l, k;

    vt[0] = '{0,    -2,   -2,   2'd2, 2'd2,  1,    0};
    vt[1] = '{0,    1,    -5,   2'd0, 2'd1,  -1,   0};
    vt[2] = '{-256, -255, -255, 2'd1, 2'd3,  -256, 0};
    vt[3] = '{-10,  5,    0,    2'd0, 2'd3,  3,    1};
    vt[4] = '{0,    -5,   4,    2'd2, 2'd1,  2,    2};
    vt[5] = '{-10,  3,    3,    2'd1, 2'd0,  1,    1};
    vt[6] = '{255,  255,  0,    2'd3, 2'd3,  255,  0};
    vt[7] = '{-256, -256, -100, 2'd0, 2'd2,  -102, 2};

    rst = 1'b1; start = 1'b0;
    for (int q = 0; q < 8; q++) begin seq_a[q] = 2'd0; seq_b[q] = 2'd0; end
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset outputs");
    rst = 1'b0;

    // Directed single-cell vectors; each traversal is aborted after cell (0,0).
    for (int v = 0; v < 8; v++) begin
      load(0, vt[v].diag); load(1, vt[v].up); load(ROW, vt[v].left);
      seq_a[0] = vt[v].ca; seq_b[0] = vt[v].cb;
      do_start(s_cyc);
      lat = -1;
      for (int t = 1; t <= 20; t++) begin
        @(posedge clk); #1;
        if (en_ins) begin lat = t; break; end
      end
      check($sformatf("vec%0d latency", v), lat, 5);
      check($sformatf("vec%0d max", v), int'(max), vt[v].emax);
      check($sformatf("vec%0d dir", v), int'(dir), vt[v].edir);
      check($sformatf("vec%0d ij", v), int'({i, j}), 0);
      rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    end

    // Reset mid-CALC: immediate abort, no pulse afterwards, stays idle.
    clear_mon();
    do_start(s_cyc);
    repeat (4) @(posedge clk);
    #1 check("busy before abort", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_all_zero("abort outputs");
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("abort en_ins count", en_i.size(), 0);
    check("abort done count", done_n, 0);
    check("abort stays idle", int'(busy), 0);

    // Randomized full-matrix runs with stray start pulses while busy.
    for (int run = 0; run < 3; run++) begin
      for (int q = 0; q < N; q++) begin
        seq_a[q] = 2'($urandom_range(0, 3));
        seq_b[q] = 2'($urandom_range(0, 3));
      end
      for (int r = 0; r <= N; r++)
        for (int c = 0; c <= N; c++) g[r][c] = int'($urandom_range(0, 511)) - 256;
      for (int q = 0; q <= N; q++) begin
        if (run == 0) begin g[0][q] = -2 * q; g[q][0] = -2 * q; end
      end
      for (int r = 0; r <= N; r++)
        for (int c = 0; c <= N; c++) load(r * ROW + c, g[r][c]);
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          d = sat(g[r][c] + ((seq_a[r] == seq_b[c]) ? 1 : -1));
          u = sat(g[r][c+1] - 2);
          l = sat(g[r+1][c] - 2);
          if (d >= u && d >= l) begin g[r+1][c+1] = d; gdir[r+1][c+1] = 0; end
          else if (u >= l)      begin g[r+1][c+1] = u; gdir[r+1][c+1] = 1; end
          else                  begin g[r+1][c+1] = l; gdir[r+1][c+1] = 2; end
        end

      clear_mon();
      do_start(s_cyc);
      for (int t = 1; t <= 150 && done_n == 0; t++) begin
        @(posedge clk); #1;
        start = (t == 20 || t == 57 || t == 90);
      end
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("run%0d done count", run), done_n, 1);
      check($sformatf("run%0d done latency", run), done_cyc - s_cyc, N * N * 7);
      check($sformatf("run%0d en_ins count", run), en_i.size(), N * N);
      check($sformatf("run%0d idle addr", run), addr_bad, 0);
      check($sformatf("run%0d busy after", run), int'(busy), 0);
      for (k = 0; k < en_i.size() && k < N * N; k++) begin
        check($sformatf("run%0d cell%0d ij", run, k), en_i[k] * 8 + en_j[k], (k / N) * 8 + (k % N));
        check($sformatf("run%0d cell%0d max", run, k), en_max[k], g[k/N+1][k%N+1]);
        check($sformatf("run%0d cell%0d dir", run, k), en_dir[k], gdir[k/N+1][k%N+1]);
        check($sformatf("run%0d cell%0d latency", run, k), en_cyc[k] - s_cyc, 5 + 7 * k);
      end
      check($sformatf("run%0d read count", run), rd_q.size(), 3 * N * N);
      for (k = 0; k < rd_q.size() && k < 3 * N * N; k++) begin
        d = (k / 3) / N; u = (k / 3) % N;
        l = (k % 3 == 0) ? d * ROW + u : (k % 3 == 1) ? d * ROW + u + 1 : (d + 1) * ROW + u;
        check($sformatf("run%0d read%0d addr", run, k), rd_q[k], l);
      end
      if (en_max.size() > 0)
        check($sformatf("run%0d final score", run), en_max[en_max.size()-1], g[N][N]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/score_cell_engine.md
SCORE_CELL_ENGINE -- requirements
Module: score_cell_engine

Interface
REQ-001 Parameter N, 128: sequence length; matrix is (N+1)x(N+1), cells (0..N-1, 0..N-1) are computed.
REQ-002 Parameter MATCH, 1; MISMATCH, -1; GAP, -2: signed 9-bit score constants.
REQ-003 Parameter AW, $clog2((N+1)*(N+1)): score RAM read address width.
REQ-004 clk  in  1  clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse; begins a traversal; matrix row 0 and column 0 are already initialised.
REQ-007 char_a, char_b  in  2 each  nucleotide codes of sequence A[i] and B[j], valid while i and j are stable.
REQ-008 rd_en  out  1  score RAM read strobe.
REQ-009 rd_addr  out  AW  score RAM read address.
REQ-010 rd_data  in  9  signed score; valid on the cycle after rd_en (1-cycle RAM latency).
REQ-011 i, j  out  $clog2(N)+1 each  current cell indices, feeding the sequence RAMs and the score writer.
REQ-012 en_ins  out  1  one-cycle pulse; max and dir are valid for cell (i,j).
REQ-013 max  out  9  signed cell score.
REQ-014 dir  out  2  traceback code: 00 diag, 01 up, 10 left.
REQ-015 busy  out  1  high from the cycle after start until done.
REQ-016 done  out  1  one-cycle pulse after the last cell.

Function
REQ-017 States: IDLE, RD_DIAG, RD_UP, RD_LEFT, CAPT, CALC, WRITE, NEXT; 7 cycles per cell.
REQ-018 IDLE->RD_DIAG on start with i=j=0; start outside IDLE is ignored.
REQ-019 RD_DIAG: rd_en=1, rd_addr=i*(N+1)+j.
REQ-020 RD_UP: rd_en=1, rd_addr=i*(N+1)+j+1; rd_data is captured as diag.
REQ-021 RD_LEFT: rd_en=1, rd_addr=(i+1)*(N+1)+j; rd_data is captured as up.
REQ-022 CAPT: rd_data is captured as left.
REQ-023 CALC: candidates are d=diag+(char_a==char_b ? MATCH : MISMATCH), u=up+GAP, l=left+GAP.
REQ-024 The sums are computed at 10 bits and saturated to [-256,255].
REQ-025 The maximum candidate and its dir are registered in CALC.
REQ-026 Tie priority: diag over up, up over left.
REQ-027 WRITE: en_ins=1 for exactly one cycle; max, dir, i and j hold stable.
REQ-028 NEXT: j increments; at j=N-1, j wraps to 0 and i increments.
REQ-029 NEXT after cell (N-1,N-1): done=1, go to IDLE, i and j return to 0.
REQ-030 Otherwise NEXT goes to RD_DIAG.
REQ-031 The gap of at least 2 cycles between en_ins and the next read of the written cell (read of (i+1,j) for the next cell) is guaranteed by WRITE->NEXT->RD_DIAG ordering. Implementations shall not shorten it.
REQ-032 rd_en is 0 in IDLE, CAPT, CALC, WRITE and NEXT; rd_addr is 0 whenever rd_en=0.
REQ-033 busy=1 in every state except IDLE.

Reset
REQ-034 While rst=1 every output is 0 and the state is IDLE.
REQ-035 The internal diag/up/left/max registers are 0 while rst=1.
REQ-036 rst asserted mid-traversal aborts immediately, with no en_ins or done pulse.
REQ-037 Operation resumes only on a new start.

Structure
REQ-038 Shared package nw_pkg holds: N, score width 9, MATCH, MISMATCH, GAP, dir encodings and the state enum.
REQ-039 Sub-module score_max3 (combinational) holds the add/saturate/compare/tie-break logic from REQ-023..026; the FSM, counters and capture registers stay in score_cell_engine.

Verification
REQ-040 Reset: assert rst mid-CALC -> next cycle all outputs 0 and state IDLE; no en_ins follows.
REQ-041 Single cell, N=4, diag=0, up=-2, left=-2, char_a=char_b=2 -> en_ins with max=1, dir=00, at i=0, j=0, 5 cycles after start.
REQ-042 Tie: diag=0 with mismatch, up=1, left=-5 -> max=-1 (d=-1, u=-1), dir=00.
REQ-043 Saturation: diag=-256 with mismatch, up=-255, left=-255 -> max=-256 (d clamps to -256, u=l=-257 clamp to -256), dir=00.
REQ-044 Full run N=4 against a RAM model -> 16 en_ins pulses in order (0,0),(0,1)..(3,3), done 112 cycles after start; the final max matches the golden NW score.
REQ-045 start pulsed while busy -> ignored, pulse count and order unchanged.
